// File: rtl/msg_text_rom.sv
// Four-message character ROM with a frame-paced typewriter reveal and a registered ASCII output.
// Optional macro TEXT_BLINK_EN: blink the fully shown message every BLINK_FRAMES frame ticks.
module msg_text_rom #(
  parameter int unsigned COLS          = 16,
  parameter int unsigned ROWS          = 2,
  parameter int unsigned REVEAL_FRAMES = 2,
  parameter int unsigned BLINK_FRAMES  = 30
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic [1:0]  msg_sel,
  input  logic        start,
  input  logic        clear,
  input  logic        frame_tick,
  input  logic [15:0] char_xy,
  output logic [6:0]  char_code,
  output logic        busy,
  output logic        done
);

  localparam int unsigned RW = $clog2(ROWS * COLS + 1);
  localparam int unsigned DW = $clog2(REVEAL_FRAMES + 1);

  typedef enum logic [1:0] {IDLE, TYPING, SHOWN} state_t;

  // Strings are right-justified in s, so character c sits (len-1-c) bytes above the LSB.
  function automatic logic [6:0] table_char(input logic [1:0] m, input int unsigned r,
                                            input int unsigned c);
    logic [95:0]  s;
    int unsigned  len;
    s   = '0;
    len = 0;
    if (r == 0) begin
      case (m)
        2'd0:    begin s = {8'h00,  "TOO SLOW!!!"}; len = 11; end
        2'd1:    begin s = {32'h00, "YOU WIN!"};    len = 8;  end
        2'd2:    begin s = {24'h00, "GET READY"};   len = 9;  end
        default: begin s = {48'h00, "PAUSED"};      len = 6;  end
      endcase
    end else if (r == 1) begin
      case (m)
        2'd0:    begin s = {16'h00, "Try again!"};  len = 10; end
        2'd1:    begin s = {8'h00,  "Press start"}; len = 11; end
        default: begin s = '0;                      len = 0;  end
      endcase
    end
    if (c < len) table_char = 7'(s >> (8 * (len - 1 - c)));
    else         table_char = '0;
  endfunction

  // Reveal end point of message m after row/column truncation.
  function automatic int unsigned calc_end(input logic [1:0] m);
    int unsigned e;
    e = 0;
    for (int unsigned r = 0; r < 2; r++) begin
      for (int unsigned c = 0; c < 12; c++) begin
        if (r < ROWS && c < COLS && table_char(m, r, c) != '0) e = r * COLS + c + 1;
      end
    end
    return e;
  endfunction

  localparam int unsigned END0 = calc_end(2'd0);
  localparam int unsigned END1 = calc_end(2'd1);
  localparam int unsigned END2 = calc_end(2'd2);
  localparam int unsigned END3 = calc_end(2'd3);

  state_t          state, state_nxt;
  logic [1:0]      sel, sel_nxt;
  logic [RW-1:0]   cnt, cnt_nxt;
  logic [DW-1:0]   div, div_nxt;
  int unsigned     end_sel;
  logic            show_ok;
  logic [31:0]     col_i, row_i, idx_i;
  logic            vis;
  logic [6:0]      code_nxt;

  always_comb begin
    case (sel)
      2'd0:    end_sel = END0;
      2'd1:    end_sel = END1;
      2'd2:    end_sel = END2;
      default: end_sel = END3;
    endcase
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // clear beats start, and start swallows a coincident frame_tick.
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    cnt_nxt   = cnt;
    div_nxt   = div;
    if (clear) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      div_nxt   = '0;
    end else if (start) begin
      state_nxt = TYPING;
      sel_nxt   = msg_sel;
      cnt_nxt   = '0;
      div_nxt   = '0;
    end else if (state == TYPING) begin
      if (frame_tick) begin
        if (32'(div) + 1 >= REVEAL_FRAMES) begin
          div_nxt = '0;
          cnt_nxt = cnt + RW'(1);
        end else begin
          div_nxt = div + DW'(1);
        end
      end
      if (32'(cnt_nxt) >= end_sel) state_nxt = SHOWN;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      sel  <= '0;
      cnt  <= '0;
      div  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      sel  <= sel_nxt;
      cnt  <= cnt_nxt;
      div  <= div_nxt;
      busy <= (state_nxt == TYPING);
      done <= (state_nxt == SHOWN);
    end
  end

`ifdef TEXT_BLINK_EN
  localparam int unsigned BW = $clog2(BLINK_FRAMES + 1);
  logic [BW-1:0] bdiv;
  logic          blink_on;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      bdiv     <= '0;
      blink_on <= 1'b1;
    end else if (state_nxt == SHOWN && state != SHOWN) begin
      bdiv     <= '0;
      blink_on <= 1'b1;
    end else if (state == SHOWN && state_nxt == SHOWN && frame_tick) begin
      if (32'(bdiv) + 1 >= BLINK_FRAMES) begin
        bdiv     <= '0;
        blink_on <= ~blink_on;
      end else begin
        bdiv     <= bdiv + BW'(1);
      end
    end
  end

  assign show_ok = blink_on;
`else
  // Static text; a zero blink period is not a legal setting.
  assign show_ok = (BLINK_FRAMES > 0);
`endif

  always_comb begin
    col_i = 32'(char_xy[15:8]);
    row_i = 32'(char_xy[7:0]);
    idx_i = row_i * COLS + col_i;
    vis   = 1'b0;
    if (col_i < COLS && row_i < ROWS) begin
      if (state == SHOWN)       vis = show_ok;
      else if (state == TYPING) vis = (idx_i < 32'(cnt));
    end
    code_nxt = vis ? table_char(sel, row_i, col_i) : '0;
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) char_code <= '0;
    else        char_code <= code_nxt;
  end

endmodule

// File: tb/tb_msg_text_rom.sv
// Randomised bench for msg_text_rom against a string-table reference model of the reveal.
module tb_msg_text_rom;

  localparam int unsigned COLS = 16;
  localparam int unsigned ROWS = 2;
  localparam int unsigned RF   = 2;
  localparam int unsigned BF   = 30;

  logic        pclk;
  logic        rst_n;
  logic [1:0]  msg_sel;
  logic        start;
  logic        clear;
  logic        frame_tick;
  logic [15:0] char_xy;
  logic [6:0]  char_code;
  logic        busy;
  logic        done;

  int unsigned n_checks;
  int unsigned n_fail;

  // model: 0 idle, 1 typing, 2 shown
  int          m_state;
  logic [1:0]  m_sel;
  int unsigned m_ticks;
  int unsigned m_bticks;

  msg_text_rom #(
    .COLS(COLS), .ROWS(ROWS), .REVEAL_FRAMES(RF), .BLINK_FRAMES(BF)
  ) dut (
    .pclk(pclk), .rst_n(rst_n), .msg_sel(msg_sel), .start(start), .clear(clear),
    .frame_tick(frame_tick), .char_xy(char_xy), .char_code(char_code),
    .busy(busy), .done(done)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic string row_text(input logic [1:0] m, input int unsigned r);
    if (r == 0) begin
      case (m)
        2'd0: return "TOO SLOW!!!";
        2'd1: return "YOU WIN!";
        2'd2: return "GET READY";
        default: return "PAUSED";
      endcase
    end
    if (r == 1) begin
      case (m)
        2'd0: return "Try again!";
        2'd1: return "Press start";
        default: return "";
      endcase
    end
    return "";
  endfunction

  function automatic int unsigned model_end(input logic [1:0] m);
    int unsigned e = 0;
    for (int unsigned r = 0; r < ROWS && r < 2; r++) begin
      string s = row_text(m, r);
      for (int unsigned c = 0; c < COLS && c < s.len(); c++) e = r * COLS + c + 1;
    end
    return e;
  endfunction

  function automatic logic [6:0] exp_char(input logic [15:0] xy);
    int unsigned c = xy[15:8];
    int unsigned r = xy[7:0];
    string       s;
    logic [7:0]  b;
    if (m_state == 0 || c >= COLS || r >= ROWS) return 7'h00;
    if (m_state == 1 && r * COLS + c >= m_ticks / RF) return 7'h00;
`ifdef TEXT_BLINK_EN
    if (m_state == 2 && ((m_bticks / BF) % 2) == 1) return 7'h00;
`endif
    s = row_text(m_sel, r);
    if (c >= s.len()) return 7'h00;
    b = s[c];
    return b[6:0];
  endfunction

  function automatic void model_reset();
    m_state  = 0;
    m_sel    = 2'd0;
    m_ticks  = 0;
    m_bticks = 0;
  endfunction

  function automatic void model_update(input bit s, input bit c, input bit t, input logic [1:0] ms);
    if (c) begin
      m_state = 0;
    end else if (s) begin
      m_state = 1;
      m_sel   = ms;
      m_ticks = 0;
    end else if (m_state == 1) begin
      if (t) m_ticks++;
      if (m_ticks / RF >= model_end(m_sel)) begin
        m_state  = 2;
        m_bticks = 0;
      end
    end else if (m_state == 2 && t) begin
      m_bticks++;
    end
  endfunction

  // Called at posedge+1; drives one cycle of inputs and checks the result after the next edge.
  task automatic step(input bit s, input bit c, input bit t, input logic [1:0] ms,
                      input logic [15:0] xy);
    logic [6:0] exp_code;
    start = s; clear = c; frame_tick = t; msg_sel = ms; char_xy = xy;
    exp_code = exp_char(xy);
    model_update(s, c, t, ms);
    @(posedge pclk);
    #1;
    check("char_code", char_code, exp_code);
    check("busy", busy, (m_state == 1) ? 1 : 0);
    check("done", done, (m_state == 2) ? 1 : 0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    model_reset();
    rst_n = 1'b0; start = 0; clear = 0; frame_tick = 0; msg_sel = 0; char_xy = 16'h0000;
    repeat (2) @(posedge pclk);
    #1;
    rst_n = 1'b1;

    // reset state
    step(0, 0, 0, 2'd0, 16'h0000);
    check("rst_code", char_code, 7'h00);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);

    // first character after two ticks, second still hidden
    step(1, 0, 0, 2'd0, 16'h0000);
    check("start_busy", busy, 1);
    step(0, 0, 1, 2'd0, 16'h0000);
    step(0, 0, 1, 2'd0, 16'h0000);
    step(0, 0, 0, 2'd0, 16'h0000);
    check("first_T", char_code, 7'h54);
    step(0, 0, 0, 2'd0, 16'h0100);
    check("second_hidden", char_code, 7'h00);

    // complete message 0 (52 ticks in total)
    for (int i = 0; i < 50; i++) step(0, 0, 1, 2'($urandom), 16'h0000);
    check("m0_done", done, 1);
    check("m0_busy", busy, 0);
    step(0, 0, 0, 2'd0, 16'h0801);
    check("m0_n", char_code, 7'h6E);
    step(0, 0, 0, 2'd0, 16'h0A00);
    check("m0_bang", char_code, 7'h21);
    step(0, 0, 0, 2'd0, 16'h0B00);
    check("m0_pad", char_code, 7'h00);
    step(0, 0, 0, 2'd0, 16'h1000);
    check("m0_col16", char_code, 7'h00);

    // restart with message 3 mid-reveal
    step(1, 0, 0, 2'd0, 16'h0000);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 2'd0, 16'h0000);
    step(1, 0, 0, 2'd3, 16'h0000);
    step(0, 0, 1, 2'd0, 16'h0000);
    check("m3_hide0", char_code, 7'h00);
    step(0, 0, 1, 2'd0, 16'h0000);
    check("m3_hide1", char_code, 7'h00);
    step(0, 0, 0, 2'd0, 16'h0000);
    check("m3_P", char_code, 7'h50);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 2'd0, 16'h0000);
    check("m3_done", done, 1);
    step(0, 0, 0, 2'd0, 16'h0000);
    check("m3_shown_P", char_code, 7'h50);

    // start + clear + tick together while shown
    step(1, 1, 1, 2'd1, 16'h0000);
    check("clr_done", done, 0);
    check("clr_busy", busy, 0);
    step(0, 0, 0, 2'd0, 16'h0000);
    check("clr_code", char_code, 7'h00);

    // asynchronous reset mid-typing
    step(1, 0, 0, 2'd1, 16'h0000);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 2'd0, 16'h0000);
    step(0, 0, 0, 2'd0, 16'h0000);
    check("pre_rst_Y", char_code, 7'h59);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_code", char_code, 7'h00);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    model_reset();
    @(posedge pclk);
    #1;
    rst_n = 1'b1;
    step(0, 0, 0, 2'd0, 16'h0000);

`ifdef TEXT_BLINK_EN
    // blink of a shown message
    step(1, 0, 0, 2'd2, 16'h0000);
    for (int i = 0; i < 18; i++) step(0, 0, 1, 2'd0, 16'h0000);
    step(0, 0, 0, 2'd0, 16'h0000);
    check("blink_on0", char_code, 7'h47);
    for (int i = 0; i < BF; i++) step(0, 0, 1, 2'd0, 16'h0000);
    step(0, 0, 0, 2'd0, 16'h0000);
    check("blink_off", char_code, 7'h00);
    check("blink_done", done, 1);
    for (int i = 0; i < BF; i++) step(0, 0, 1, 2'd0, 16'h0000);
    step(0, 0, 0, 2'd0, 16'h0000);
    check("blink_on1", char_code, 7'h47);
`endif

    // random traffic
    for (int i = 0; i < 5000; i++) begin
      bit          s, c, t;
      logic [15:0] xy;
      s  = ($urandom_range(0, 299) == 0);
      c  = ($urandom_range(0, 599) == 0);
      t  = ($urandom_range(0, 2) == 0);
      xy = {8'($urandom_range(0, 17)), 8'($urandom_range(0, 2))};
      step(s, c, t, 2'($urandom), xy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
